// File: rtl/rfid_pkg.sv
// Shared types and reply-frame constants for the RFID reader link.
// Pure declarations: no logic, no latency, no flow control.
package rfid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_TX,
        ST_RESP,
        ST_HOLD
    } poll_state_t;

    localparam logic [7:0] RFID_HDR         = 8'hBB;
    localparam logic [7:0] RFID_TYPE_NOTICE = 8'h02;
    localparam logic [7:0] RFID_END         = 8'h7E;
    localparam int         RFID_RESP_LEN    = 7;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider: one-cycle baud_tick every DIV clocks, first tick DIV-1 cycles after reset.
// No handshake; the tick is combinational from the divider count and never stalls.
module baud_tick_gen
    import rfid_pkg::*;
#(
    parameter int DIV = 2500
) (
    input  logic clk_24M,
    input  logic rst,
    output logic baud_tick
);

    localparam int           W    = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign baud_tick = (cnt == LAST);

endmodule

// File: rtl/rfid_poll_ctrl.sv
// RFID poll sequencer: trigger frame_tx, await and parse the 7-byte reply, retry on timeout, report tag or no-tag.
// tx_trig_n, tag_valid and no_tag are registered (one cycle after the deciding state); rx bytes are never stalled.
module rfid_poll_ctrl
    import rfid_pkg::*;
#(
    parameter int CLK_HZ    = 24_000_000,
    parameter int BAUD      = 9600,
    parameter int POLL_CYC  = 4_800_000,
    parameter int RESP_CYC  = 1_200_000,
    parameter int MAX_RETRY = 3,
    parameter int TRIG_LEN  = 4
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        enable,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        baud_tick,
    output logic        tx_trig_n,
    output logic        busy,
    output logic        tag_valid,
    output logic [31:0] tag_id,
    output logic        no_tag
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = cnt_w(TRIG_LEN);
    localparam int RW  = cnt_w(RESP_CYC);
    localparam int PW  = cnt_w(POLL_CYC);
    localparam int NW  = cnt_w(MAX_RETRY);

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_LEN - 1);
    localparam logic [RW-1:0] RESP_LAST = RW'(RESP_CYC - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(RFID_RESP_LEN - 1);

    poll_state_t   state_q;
    poll_state_t   state_d;
    logic [TW-1:0] trig_cnt;
    logic [RW-1:0] resp_cnt;
    logic [PW-1:0] hold_cnt;
    logic [NW-1:0] retry_cnt;
    logic [2:0]    idx;
    logic [31:0]   id_hold;
    logic          abort;
    logic          frame_end;
    logic          retry_last;
    logic          good_frame;
    logic          timeout;
    logic          give_up;

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk_24M   (clk_24M),
        .rst       (rst),
        .baud_tick (baud_tick)
    );

    assign frame_end  = rx_valid && (idx == IDX_LAST) && (rx_byte == RFID_END);
    assign retry_last = (int'(retry_cnt) + 1) == MAX_RETRY;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Good frame is tested before the timeout so it wins a same-cycle tie.
    always_comb begin
        state_d    = state_q;
        good_frame = 1'b0;
        timeout    = 1'b0;
        give_up    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (trig_cnt == TRIG_LAST) state_d = ST_TX;
            end
            ST_TX: begin
                if (tx_done) state_d = (abort || !enable) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_end) begin
                    good_frame = 1'b1;
                    state_d    = ST_HOLD;
                end else if (resp_cnt == RESP_LAST) begin
                    timeout = 1'b1;
                    if (retry_last) begin
                        give_up = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_TRIG;
                    end
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt == POLL_LAST) begin
                    state_d = ST_TRIG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            trig_cnt  <= '0;
            resp_cnt  <= '0;
            hold_cnt  <= '0;
            retry_cnt <= '0;
            abort     <= 1'b0;
            tx_trig_n <= 1'b1;
            tag_valid <= 1'b0;
            no_tag    <= 1'b0;
            tag_id    <= '0;
        end else begin
            tx_trig_n <= (state_q != ST_TRIG);
            tag_valid <= good_frame;
            no_tag    <= give_up;
            if (good_frame) tag_id <= id_hold;

            if (state_q == ST_TRIG && trig_cnt != TRIG_LAST) trig_cnt <= trig_cnt + TW'(1);
            else                                             trig_cnt <= '0;

            if (state_q != ST_RESP)        resp_cnt <= '0;
            else if (resp_cnt != RESP_LAST) resp_cnt <= resp_cnt + RW'(1);

            if (state_q != ST_HOLD)        hold_cnt <= '0;
            else if (hold_cnt != POLL_LAST) hold_cnt <= hold_cnt + PW'(1);

            if (state_q == ST_IDLE || good_frame || give_up) retry_cnt <= '0;
            else if (timeout)                                retry_cnt <= retry_cnt + NW'(1);

            // An enable drop during the trigger/frame is remembered until tx_done.
            if (state_q == ST_TX && tx_done)                                  abort <= 1'b0;
            else if ((state_q == ST_TRIG || state_q == ST_TX) && !enable)     abort <= 1'b1;
        end
    end

    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            id_hold <= '0;
        end else if (state_q != ST_RESP) begin
            idx <= '0;
        end else if (rx_valid) begin
            case (idx)
                3'd0: idx <= (rx_byte == RFID_HDR) ? 3'd1 : 3'd0;
                3'd1: begin
                    if (rx_byte == RFID_TYPE_NOTICE) idx <= 3'd2;
                    else                             idx <= (rx_byte == RFID_HDR) ? 3'd1 : 3'd0;
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    id_hold <= {id_hold[23:0], rx_byte};
                    idx     <= idx + 3'd1;
                end
                default: idx <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_rfid_poll_ctrl.sv
// Directed bench for rfid_poll_ctrl with DIV=4, POLL_CYC=20, RESP_CYC=30, MAX_RETRY=3.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
`timescale 1ns/1ps
module tb_rfid_poll_ctrl;

    localparam int BAUD   = 9600;
    localparam int CLK_HZ = BAUD * 4;

    logic        clk_24M  = 1'b0;
    logic        rst      = 1'b0;
    logic        enable   = 1'b0;
    logic        tx_done  = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte  = 8'h00;
    logic        baud_tick;
    logic        tx_trig_n;
    logic        busy;
    logic        tag_valid;
    logic [31:0] tag_id;
    logic        no_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk_24M = ~clk_24M;

    rfid_poll_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .POLL_CYC  (20),
        .RESP_CYC  (30),
        .MAX_RETRY (3),
        .TRIG_LEN  (4)
    ) dut (
        .clk_24M   (clk_24M),
        .rst       (rst),
        .enable    (enable),
        .tx_done   (tx_done),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .baud_tick (baud_tick),
        .tx_trig_n (tx_trig_n),
        .busy      (busy),
        .tag_valid (tag_valid),
        .tag_id    (tag_id),
        .no_tag    (no_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Baud reference: tick on every fourth clock after reset release.
    int   bm;
    logic bchk = 1'b0;
    always @(posedge clk_24M or negedge rst) begin
        if (!rst) bm <= 0;
        else      bm <= (bm == 3) ? 0 : bm + 1;
    end
    always @(negedge clk_24M) begin
        if (rst && bchk) chk("baud_tick", 32'(baud_tick), 32'(bm == 3));
    end

    typedef struct {
        logic       en;
        logic       txd;
        logic       rv;
        logic [7:0] rb;
        logic       e_trig_n;
        logic       e_busy;
        logic       e_tv;
        logic       e_nt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic en, input logic txd, input logic rv, input logic [7:0] rb,
                       input logic etn, input logic eb, input logic etv, input logic ent);
        vec_t v;
        v.en = en; v.txd = txd; v.rv = rv; v.rb = rb;
        v.e_trig_n = etn; v.e_busy = eb; v.e_tv = etv; v.e_nt = ent;
        vt.push_back(v);
    endtask

    task automatic step(input logic en, input logic txd, input logic rv, input logic [7:0] rb);
        enable   = en;
        tx_done  = txd;
        rx_valid = rv;
        rx_byte  = rb;
        @(posedge clk_24M);
        @(negedge clk_24M);
        tx_done  = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wait_trig(input logic lvl, input string name, output int n);
        n = 0;
        while (tx_trig_n !== lvl && n < 200) begin
            step(enable, 1'b0, 1'b0, 8'h00);
            n++;
        end
        if (tx_trig_n !== lvl) begin
            checks++;
            failures++;
            $display("FAIL %s: tx_trig_n stuck at %0b, wanted %0b", name, tx_trig_n, lvl);
        end
    endtask

    // Acts as frame_tx: let the trigger finish, then report the frame sent.
    task automatic frame_done(input string name);
        int n;
        wait_trig(1'b0, name, n);
        wait_trig(1'b1, name, n);
        step(enable, 1'b1, 1'b0, 8'h00);
    endtask

    logic [7:0] f1[7] = '{8'hBB, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7E};
    logic [7:0] f2[8] = '{8'hBB, 8'hBB, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h7E};
    logic [7:0] f3[7] = '{8'hBB, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   n;
        int   trigs;
        int   lows;
        int   first_low;
        logic seen;

        // Enable, trigger, good reply, 20-cycle hold, next trigger, TX.
        add(1, 0, 0, 8'h00, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 1, 0, 0);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0);
        add(1, 1, 0, 8'h00, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(1, 0, 1, f1[k], 1, 1, (k == 6), 0);
        for (int i = 0; i < 20; i++) add(1, 0, 0, 8'h00, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 1, 0, 0);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0);

        repeat (3) @(negedge clk_24M);
        chk("rst_trig_n", 32'(tx_trig_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tag_valid", 32'(tag_valid), 32'd0);
        chk("rst_no_tag", 32'(no_tag), 32'd0);
        chk("rst_tag_id", tag_id, 32'd0);
        chk("rst_baud_tick", 32'(baud_tick), 32'd0);
        rst  = 1'b1;
        bchk = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].en, vt[i].txd, vt[i].rv, vt[i].rb);
            chk($sformatf("vec%0d_trig_n", i), 32'(tx_trig_n), 32'(vt[i].e_trig_n));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_tag_valid", i), 32'(tag_valid), 32'(vt[i].e_tv));
            chk($sformatf("vec%0d_no_tag", i), 32'(no_tag), 32'(vt[i].e_nt));
        end
        chk("t2_tag_id", tag_id, 32'h12345678);

        // No reply: two retries 31 cycles apart, then no_tag 30 cycles after the third tx_done.
        trigs = 1;
        for (int r = 1; r <= 3; r++) begin
            step(1, 1, 0, 8'h00);
            n = 0;
            while (tx_trig_n === 1'b1 && no_tag !== 1'b1 && n < 200) begin
                step(1, 0, 0, 8'h00);
                n++;
            end
            if (r < 3) begin
                chk("t3_retry_delay", n, 31);
                chk("t3_retry_trig", 32'(tx_trig_n), 32'd0);
                if (tx_trig_n === 1'b0) trigs++;
                wait_trig(1'b1, "t3_retry_tx", n);
            end else begin
                chk("t3_no_tag_delay", n, 30);
                chk("t3_no_tag", 32'(no_tag), 32'd1);
                chk("t3_no_tag_trig_n", 32'(tx_trig_n), 32'd1);
                step(1, 0, 0, 8'h00);
                chk("t3_no_tag_width", 32'(no_tag), 32'd0);
            end
        end
        chk("t3_trig_total", trigs, 3);
        chk("t3_tag_id_kept", tag_id, 32'h12345678);

        // Repeated header byte, then a frame with a bad end byte.
        frame_done("t4a");
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 1, f2[k]);
            if (k < 7) seen = seen | tag_valid;
        end
        chk("t4_tv_early", 32'(seen), 32'd0);
        chk("t4_tag_valid", 32'(tag_valid), 32'd1);
        chk("t4_tag_id", tag_id, 32'hAABBCCDD);

        frame_done("t4b");
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1, 0, 1, f3[k]);
            seen = seen | tag_valid | no_tag;
        end
        n = 0;
        while (tx_trig_n === 1'b1 && n < 200) begin
            step(1, 0, 0, 8'h00);
            seen = seen | tag_valid | no_tag;
            n++;
        end
        chk("t4_bad_end_retry", 7 + n, 31);
        chk("t4_bad_end_pulse", 32'(seen), 32'd0);
        chk("t4_tag_id_kept", tag_id, 32'hAABBCCDD);

        // Enable dropped in TX: wait for tx_done, then straight to IDLE.
        wait_trig(1'b1, "t5_tx", n);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("t5_tx_busy", 32'(busy), 32'd1);
        step(0, 1, 0, 8'h00);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 1, f1[k]);
            seen = seen | tag_valid | busy | ~tx_trig_n;
        end
        chk("t5_idle_quiet", 32'(seen), 32'd0);

        // Enable dropped in RESP: IDLE on the next edge, no pulses afterwards.
        step(1, 0, 0, 8'h00);
        frame_done("t5b");
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("t5b_resp_busy", 32'(busy), 32'd1);
        step(0, 0, 0, 8'h00);
        chk("t5b_idle_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 0, 8'h00);
            seen = seen | tag_valid | no_tag | busy | ~tx_trig_n;
        end
        chk("t5b_idle_quiet", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a trigger.
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("t6_trig_low", 32'(tx_trig_n), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_trig_n", 32'(tx_trig_n), 32'd1);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_tag_id", tag_id, 32'd0);
        @(negedge clk_24M);
        @(negedge clk_24M);
        rst = 1'b1;
        lows = 0;
        first_low = -1;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 8'h00);
            if (tx_trig_n === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = k;
            end
        end
        chk("t6_trig_start", first_low, 1);
        chk("t6_trig_len", lows, 4);
        chk("t6_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
